// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: register tags and write enables in, pipeline stall/flush/forward controls out.
// Latency: none, a plain wire bundle.
// Backpressure: none; the stall outputs carried here are themselves the backpressure into the pipeline.
interface hazard_ctrl_unit_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic              RegWriteE, RegWriteM, RegWriteW;
   logic              ResultSrcE0, PCSrcE, MduStartE, ClrCnt;
   logic              StallF, StallD, StallE;
   logic              FlushD, FlushE, FlushM;
   logic [1:0]        ForwardAE, ForwardBE;
   logic              MduBusy;
   logic [CNT_W-1:0]  StallCnt, FlushCnt;

   // Datapath side: drives register tags and control, receives hazard controls.
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteE, RegWriteM, RegWriteW,
      output ResultSrcE0, PCSrcE, MduStartE, ClrCnt,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
      input  ForwardAE, ForwardBE, MduBusy, StallCnt, FlushCnt
   );

   // Hazard unit side.
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteE, RegWriteM, RegWriteW,
      input  ResultSrcE0, PCSrcE, MduStartE, ClrCnt,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM,
      output ForwardAE, ForwardBE, MduBusy, StallCnt, FlushCnt
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding selects, load-use/RAW interlock, MDU hold FSM, branch flush, perf counters.
// Latency: stall/flush/forward controls are combinational; counters and MDU state update on the next clk edge.
// Backpressure: generates it (StallF/StallD/StallE); accepts none.
module hazard_ctrl_unit #(
   parameter int REG_AW  = 5,
   parameter int FWD_EN  = 1,
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_ctrl_unit_if.slave hz
);
   // Down-counter only needs to hold MDU_LAT-2.
   localparam int             MCW      = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
   localparam bit             MDU_EN   = (MDU_LAT >= 2);
   localparam logic [MCW-1:0] MDU_LOAD = MDU_EN ? MCW'(MDU_LAT - 2) : '0;

   typedef enum logic {IDLE, BUSY} mdu_state_e;

   mdu_state_e       state_q, state_d;
   logic [MCW-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             mdu_stall, raw_stall, stall_f;
   logic             dep_e, dep_m;
   logic [1:0]       fwd_a, fwd_b;

   // Operand select for one E-stage source: newest producer (M) beats older (W); x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rd_m, input logic we_m,
                                          input logic [REG_AW-1:0] rd_w, input logic we_w);
      if (rs != '0 && rs == rd_m && we_m) return 2'b10;
      if (rs != '0 && rs == rd_w && we_w) return 2'b01;
      return 2'b00;
   endfunction

   // True when the instruction in D reads a register that a later stage is about to write.
   function automatic logic dep(input logic [REG_AW-1:0] rd, input logic we,
                                input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
      return (rd != '0) && we && (rs1 == rd || rs2 == rd);
   endfunction

   // Forwarding selects and RAW interlock; without forwarding every pending write to a D source interlocks.
   always_comb begin
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
      dep_e     = dep(hz.RdE, hz.RegWriteE, hz.Rs1D, hz.Rs2D);
      dep_m     = dep(hz.RdM, hz.RegWriteM, hz.Rs1D, hz.Rs2D);
      raw_stall = dep_e | dep_m;
      if (FWD_EN != 0) begin
         fwd_a     = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
         fwd_b     = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
         raw_stall = hz.ResultSrcE0 & dep_e;
      end
   end

   // MDU hold sequencing: first cycle stalls from IDLE, BUSY counts down, counter==0 is the release cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mdu_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (MDU_EN && hz.MduStartE && !hz.PCSrcE) begin
               mdu_stall = 1'b1;
               cnt_d     = MDU_LOAD;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               mdu_stall = 1'b1;
               cnt_d     = cnt_q - MCW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A redirect while the MDU holds E kills the MDU instruction; the sequence is abandoned.
      if (hz.PCSrcE && state_q == BUSY) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   assign stall_f = raw_stall | mdu_stall;

   // Saturating performance counters; clear beats increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hz.ClrCnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_f && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (hz.PCSrcE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // E is held (not flushed) while the MDU works; a bubble goes into M behind it.
   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_f;
   assign hz.StallE    = mdu_stall;
   assign hz.FlushM    = mdu_stall;
   assign hz.FlushD    = hz.PCSrcE;
   assign hz.FlushE    = (raw_stall & ~mdu_stall) | hz.PCSrcE;
   assign hz.ForwardAE = fwd_a;
   assign hz.ForwardBE = fwd_b;
   assign hz.MduBusy   = mdu_stall;
   assign hz.StallCnt  = stall_cnt_q;
   assign hz.FlushCnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: four builds (default, no-forwarding, MDU_LAT=1, MDU_LAT=2/CNT_W=4) on shared stimulus.
// Latency: outputs compared at every negedge against a behavioural model; directed literals pin the model.
// Backpressure: not applicable.
module tb_hazard_ctrl_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic       rwe, rwm, rww, rse0, pc, start, clr;

   logic [3:0]  sf, sd, se, fd, fe, fm, mb;
   logic [1:0]  fa [4];
   logic [1:0]  fb [4];
   logic [15:0] sc [4];
   logic [15:0] fc [4];

   for (genvar g = 0; g < 4; g++) begin : u
      localparam int FW = (g == 1) ? 0 : 1;
      localparam int LT = (g == 2) ? 1 : ((g == 3) ? 2 : 4);
      localparam int CW = (g == 3) ? 4 : 16;
      hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(CW)) hif ();
      assign hif.Rs1D = rs1d;  assign hif.Rs2D = rs2d;
      assign hif.Rs1E = rs1e;  assign hif.Rs2E = rs2e;
      assign hif.RdE  = rde;   assign hif.RdM  = rdm;   assign hif.RdW = rdw;
      assign hif.RegWriteE = rwe; assign hif.RegWriteM = rwm; assign hif.RegWriteW = rww;
      assign hif.ResultSrcE0 = rse0; assign hif.PCSrcE = pc;
      assign hif.MduStartE = start;  assign hif.ClrCnt = clr;
      hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(FW), .MDU_LAT(LT), .CNT_W(CW)) dut (
         .clk(clk), .rst_n(rst_n), .hz(hif));
      assign sf[g] = hif.StallF;  assign sd[g] = hif.StallD;  assign se[g] = hif.StallE;
      assign fd[g] = hif.FlushD;  assign fe[g] = hif.FlushE;  assign fm[g] = hif.FlushM;
      assign mb[g] = hif.MduBusy;
      assign fa[g] = hif.ForwardAE; assign fb[g] = hif.ForwardBE;
      assign sc[g] = 16'(hif.StallCnt);
      assign fc[g] = 16'(hif.FlushCnt);
   end

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int g, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cfg%0d: got %0d expected %0d @%0t", name, g, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic sf, se, fd, fe, fm, mb;
      logic [1:0] fa, fb;
   } exp_t;

   // mk = 1-based cycle index of the MDU instruction currently sitting in E, 0 when none.
   int mk [4]  = '{0, 0, 0, 0};
   int msc [4] = '{0, 0, 0, 0};
   int mfc [4] = '{0, 0, 0, 0};

   function automatic bit cfg_fwd(int g); return g != 1; endfunction
   function automatic int cfg_lat(int g); return (g == 2) ? 1 : ((g == 3) ? 2 : 4); endfunction
   function automatic int cfg_max(int g); return (g == 3) ? 15 : 65535; endfunction

   function automatic logic [1:0] m_fwd(int g, logic [4:0] rs);
      if (!cfg_fwd(g) || rs == 0) return 2'd0;
      if (rs == rdm && rwm) return 2'd2;
      if (rs == rdw && rww) return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit m_dep(logic [4:0] rd, logic we);
      return rd != 0 && we && (rs1d == rd || rs2d == rd);
   endfunction

   function automatic exp_t model_out(int g, int k);
      exp_t e;
      bit raw, mdu;
      raw = cfg_fwd(g) ? (rse0 && m_dep(rde, rwe)) : (m_dep(rde, rwe) || m_dep(rdm, rwm));
      mdu = (k == 0) ? (start && !pc && cfg_lat(g) >= 2) : (k < cfg_lat(g));
      e.sf = raw | mdu;
      e.se = mdu;
      e.fm = mdu;
      e.mb = mdu;
      e.fd = pc;
      e.fe = (raw && !mdu) || pc;
      e.fa = m_fwd(g, rs1e);
      e.fb = m_fwd(g, rs2e);
      return e;
   endfunction

   exp_t mdl_e, cmp_e;

   // Model state advance on each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < 4; g++) begin
            mk[g] <= 0; msc[g] <= 0; mfc[g] <= 0;
         end
      end else begin
         for (int g = 0; g < 4; g++) begin
            mdl_e = model_out(g, mk[g]);
            if (mk[g] == 0)                     mk[g] <= mdl_e.mb ? 2 : 0;
            else if (pc || mk[g] >= cfg_lat(g)) mk[g] <= 0;
            else                                mk[g] <= mk[g] + 1;
            if (clr) begin
               msc[g] <= 0; mfc[g] <= 0;
            end else begin
               if (mdl_e.sf && msc[g] < cfg_max(g)) msc[g] <= msc[g] + 1;
               if (pc && mfc[g] < cfg_max(g))       mfc[g] <= mfc[g] + 1;
            end
         end
      end
   end

   // Full output comparison against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < 4; g++) begin
            cmp_e = model_out(g, mk[g]);
            check("StallF", g, sf[g], cmp_e.sf);
            check("StallD", g, sd[g], cmp_e.sf);
            check("StallE", g, se[g], cmp_e.se);
            check("FlushD", g, fd[g], cmp_e.fd);
            check("FlushE", g, fe[g], cmp_e.fe);
            check("FlushM", g, fm[g], cmp_e.fm);
            check("MduBusy", g, mb[g], cmp_e.mb);
            check("ForwardAE", g, fa[g], cmp_e.fa);
            check("ForwardBE", g, fb[g], cmp_e.fb);
            check("StallCnt", g, sc[g], msc[g]);
            check("FlushCnt", g, fc[g], mfc[g]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
      rwe = 0; rwm = 0; rww = 0; rse0 = 0; pc = 0; start = 0; clr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counters();
      idle();
      clr = 1;
      tick();
      clr = 0;
   endtask

   initial begin
      idle();
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) tick();
      check("rst_StallCnt", 0, sc[0], 0);
      check("rst_FlushCnt", 0, fc[0], 0);
      check("rst_MduBusy", 0, mb[0], 0);
      rst_n = 1'b1;
      tick();

      // Forwarding priority: M over W, x0 never forwarded, disabled build always 00.
      rs1e = 5; rs2e = 5; rdm = 5; rdw = 5; rwm = 1; rww = 1;
      #2;
      check("fwdA_M", 0, fa[0], 2);
      check("fwdB_M", 0, fb[0], 2);
      check("fwdA_nofwd", 1, fa[1], 0);
      tick();
      rwm = 0;
      #2;
      check("fwdA_W", 0, fa[0], 1);
      tick();
      rs1e = 0;
      #2;
      check("fwdA_x0", 0, fa[0], 0);
      check("fwdB_W", 0, fb[0], 1);
      tick();

      // Load-use interlock.
      idle();
      rse0 = 1; rde = 7; rwe = 1; rs2d = 7;
      #2;
      check("lu_StallF", 0, sf[0], 1);
      check("lu_StallD", 0, sd[0], 1);
      check("lu_FlushE", 0, fe[0], 1);
      check("lu_StallE", 0, se[0], 0);
      tick();
      rde = 0;
      #2;
      check("lu_x0_StallF", 0, sf[0], 0);
      check("lu_x0_FlushE", 0, fe[0], 0);
      tick();

      // No-forwarding build interlocks on an M-stage producer.
      idle();
      rdm = 9; rwm = 1; rs1d = 9; rs1e = 9;
      #2;
      check("nf_StallF", 1, sf[1], 1);
      check("nf_StallD", 1, sd[1], 1);
      check("nf_FlushE", 1, fe[1], 1);
      check("nf_fwdA", 1, fa[1], 0);
      check("fw_noStall", 0, sf[0], 0);
      check("fw_fwdA", 0, fa[0], 2);
      tick();

      // Two back-to-back MDU ops (start held 8 cycles): busy 1,1,1,0,1,1,1,0.
      clear_counters();
      start = 1;
      for (int i = 0; i < 8; i++) begin
         #2;
         check("mdu_busy", 0, mb[0], (i % 4 != 3) ? 1 : 0);
         check("mdu_StallE", 0, se[0], (i % 4 != 3) ? 1 : 0);
         check("mdu_FlushM", 0, fm[0], (i % 4 != 3) ? 1 : 0);
         check("mdu_lat1", 2, mb[2], 0);
         check("mdu_lat2", 3, mb[3], (i % 2 == 0) ? 1 : 0);
         tick();
      end
      start = 0;
      #2;
      check("mdu_StallCnt", 0, sc[0], 6);
      check("mdu_StallCnt_lat1", 2, sc[2], 0);
      check("mdu_StallCnt_lat2", 3, sc[3], 4);
      tick();

      // Branch flush from IDLE.
      clear_counters();
      pc = 1;
      #2;
      check("br_FlushD", 0, fd[0], 1);
      check("br_FlushE", 0, fe[0], 1);
      check("br_busy", 0, mb[0], 0);
      tick();
      pc = 0;
      #2;
      check("br_FlushD_off", 0, fd[0], 0);
      check("br_FlushCnt", 0, fc[0], 1);
      tick();

      // Branch while the MDU is busy: flush wins, FSM back to IDLE next cycle.
      start = 1;
      #2;
      check("bb_busy1", 0, mb[0], 1);
      tick();
      pc = 1;
      #2;
      check("bb_busy2", 0, mb[0], 1);
      check("bb_FlushD", 0, fd[0], 1);
      check("bb_FlushE", 0, fe[0], 1);
      tick();
      pc = 0; start = 0;
      #2;
      check("bb_idle", 0, mb[0], 0);
      tick();
      start = 1;
      #2;
      check("bb_restart", 0, mb[0], 1);
      repeat (3) tick();
      start = 0;
      tick();

      // Saturation on the 4-bit counter, then clear priority over increment.
      clear_counters();
      rse0 = 1; rde = 7; rwe = 1; rs1d = 7;
      repeat (20) tick();
      #2;
      check("sat_cnt4", 3, sc[3], 15);
      check("sat_cnt16", 0, sc[0], 20);
      clr = 1;
      tick();
      clr = 0;
      #2;
      check("clr_cnt16", 0, sc[0], 0);
      check("clr_cnt4", 3, sc[3], 0);
      tick();

      // Mixed traffic over small register numbers so tags collide often.
      for (int i = 0; i < 300; i++) begin
         rs1d = 5'($urandom_range(3, 0)); rs2d = 5'($urandom_range(3, 0));
         rs1e = 5'($urandom_range(3, 0)); rs2e = 5'($urandom_range(3, 0));
         rde  = 5'($urandom_range(3, 0)); rdm  = 5'($urandom_range(3, 0));
         rdw  = 5'($urandom_range(3, 0));
         rwe  = 1'($urandom_range(1, 0)); rwm = 1'($urandom_range(1, 0));
         rww  = 1'($urandom_range(1, 0)); rse0 = 1'($urandom_range(1, 0));
         pc    = ($urandom_range(7, 0) == 0);
         start = ($urandom_range(2, 0) == 0);
         clr   = ($urandom_range(31, 0) == 0);
         tick();
      end

      // Asynchronous reset in the middle of an MDU hold.
      idle();
      repeat (5) tick();
      start = 1;
      tick();
      start = 0;
      #2;
      check("ar_busy_before", 0, mb[0], 1);
      rst_n = 1'b0;
      #1;
      check("ar_busy_after", 0, mb[0], 0);
      check("ar_StallE_after", 0, se[0], 0);
      check("ar_StallCnt", 0, sc[0], 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage RV32 core.
- Generates forwarding selects, load-use stalls and branch flushes, as the current hazard logic does.
- Adds a multi-cycle execute-unit (MDU) stall FSM, a no-forwarding build mode, and saturating stall/flush performance counters.
- Sits beside the datapath; drives the stall and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- REG_AW, 5, register address width.
- FWD_EN, 1, 1 = forwarding enabled; 0 = interlock on every RAW hazard.
- MDU_LAT, 4, cycles an MDU instruction occupies E (legal range >=1).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  REG_AW  source registers in D.
- Rs1E, Rs2E, RdE  in  REG_AW  source and destination registers in E.
- RdM, RdW  in  REG_AW  destination registers in M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- ResultSrcE0  in  1  load instruction in E.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MduStartE  in  1  MDU instruction in E.
- ClrCnt  in  1  synchronous clear of both counters.
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers.
- FlushD, FlushE, FlushM  out  1  bubble into IF/ID, ID/EX and EX/MEM.
- ForwardAE, ForwardBE  out  2  operand selects: 00 register file, 01 W result, 10 M result.
- MduBusy  out  1  MDU stall active.
- StallCnt, FlushCnt  out  CNT_W  performance counters.

Behaviour:
- Reset (rst_n low, asynchronous): FSM = IDLE, internal down-counter = 0, StallCnt = 0, FlushCnt = 0. Combinational outputs then evaluate with MduBusy = 0.
- Forwarding (FWD_EN=1), combinational, per operand:
  - 10 if Rs!=0, Rs==RdM and RegWriteM.
  - Else 01 if Rs!=0, Rs==RdW and RegWriteW.
  - Else 00.
  - The M match takes priority over the W match.
- FWD_EN=0: ForwardAE = ForwardBE = 00.
- Dependence test dep(X) = RdX!=0 and RegWriteX and (Rs1D==RdX or Rs2D==RdX).
- rawStall:
  - FWD_EN=1: ResultSrcE0 and dep(E).
  - FWD_EN=0: dep(E) or dep(M).
  - x0 never causes a stall.
- MDU FSM states: IDLE, BUSY.
  - IDLE with MduStartE=1, PCSrcE=0 and MDU_LAT>=2: mduStall=1 this cycle; load counter with MDU_LAT-2; next state BUSY.
  - BUSY with counter!=0: mduStall=1; counter decrements.
  - BUSY with counter==0: mduStall=0; next state IDLE. MduStartE is ignored in this cycle (release cycle; the same instruction is still in E).
  - Result: MDU_LAT-1 stall cycles per MDU instruction, and the instruction occupies E for MDU_LAT cycles.
  - MDU_LAT=1: the FSM never leaves IDLE and there are no stalls.
- MduBusy = mduStall.
- Output equations:
  - StallF = StallD = rawStall | mduStall.
  - StallE = mduStall.
  - FlushM = mduStall (bubble behind the held E stage).
  - FlushD = PCSrcE.
  - FlushE = (rawStall & ~mduStall) | PCSrcE. E is held, never flushed, while the MDU is busy.
- PCSrcE in BUSY is a protocol violation, handled as defined behaviour:
  - Flush wins: FlushD = FlushE = 1.
  - FSM is forced to IDLE next cycle with counter = 0.
  - mduStall still follows the current state during that cycle.
- Counters, updated on the clk rising edge:
  - StallCnt += 1 when StallF=1.
  - FlushCnt += 1 when PCSrcE=1.
  - Both saturate at all ones; no wrap.
  - ClrCnt has priority over increment and zeroes both counters.
- Back-to-back MDU instructions: the second MduStartE is seen in IDLE the cycle after release and starts a new sequence. There is no gap stall beyond the release cycle.

Test Plan:
- Forward priority: Rs1E=5, RdM=5, RdW=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, RegWriteE=1, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0. RdE=0 -> no stall.
- MDU_LAT=4, MduStartE held for 4 cycles -> MduBusy/StallE/FlushM high for exactly 3 cycles, low on the 4th; StallCnt increases by 3. With MDU_LAT=1 -> no stall.
- FWD_EN=0: RdM=9, RegWriteM=1, Rs1D=9 -> StallF=StallD=1, FlushE=1, ForwardAE=00.
- PCSrcE pulse in IDLE -> FlushD=FlushE=1 for one cycle, FlushCnt +1. PCSrcE in BUSY -> FSM in IDLE next cycle.
- Saturation and reset: CNT_W=4 with 20 stall cycles -> StallCnt=15. ClrCnt -> 0. rst_n low mid-BUSY -> MduBusy=0 immediately, with no clock edge.
